// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stalls, redirect flushes, MDU hold
//
// Purpose: decides stage-register enables and bubble insertion for a 5-stage
// pipeline. It handles load-use interlocks, branch/jump redirects, fetch
// misses and multicycle MDU operations, which are guarded by a watchdog.
// It also keeps saturating stall/flush performance counters.
//
// Ports:
//   clk                       single clock, rising edge
//   reset                     synchronous, active-low (0 = reset)
//   ifid_rs1/rs2, use_rs1/2   sources read by the instruction in ID
//   idex_rd, idex_mem_read,
//   idex_valid                destination / load flag / valid of the EX instruction
//   ex_redirect               branch/jump in EX redirects the PC
//   mdu_start, mdu_done       multicycle op enters EX / result ready
//   imem_ready                fetch data valid
//   pc_en, ifid_en, idex_en   stage register enables
//   ifid/idex/exmem_flush     load a bubble into that stage register
//   ctrl_state                RUN=0, LU_STALL=1, MDU_BUSY=2
//   mdu_timeout               sticky watchdog flag
//   stall_cnt, flush_cnt      saturating performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_valid,
  input  logic             ex_redirect,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       ctrl_state,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MDU_BUSY = 2'd2
  } state_e;

  // The first load-use bubble is issued from RUN, so LU_STALL covers the rest.
  localparam logic [1:0] LU_CNT_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [7:0] TIMER_LAST  = 8'(MDU_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [7:0]       timer_q, timer_d;
  logic             mdu_timeout_q, mdu_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_inc;
  logic             load_use;

  // x0 is never a real dependency, so a load to x0 must not interlock.
  assign load_use = idex_valid && idex_mem_read && (idex_rd != 5'd0) &&
                    (((idex_rd == ifid_rs1) && ifid_use_rs1) ||
                     ((idex_rd == ifid_rs2) && ifid_use_rs2));

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    timer_d       = timer_q;
    mdu_timeout_d = mdu_timeout_q;
    flush_inc     = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (mdu_start) begin
          // A single-cycle MDU result needs no hold at all.
          if (!mdu_done) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            timer_d     = 8'd0;
            state_d     = MDU_BUSY;
          end
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_CNT_INIT;
          end
        end else if (!imem_ready) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end

      LU_STALL: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        lu_cnt_d   = lu_cnt_q - 2'd1;
        if (lu_cnt_q == 2'd1) begin
          state_d = RUN;
        end
      end

      MDU_BUSY: begin
        timer_d = timer_q + 8'd1;
        if (mdu_done) begin
          state_d = RUN;
        end else if (timer_q == TIMER_LAST) begin
          // Watchdog: release the pipeline and leave a sticky flag behind.
          mdu_timeout_d = 1'b1;
          state_d       = RUN;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset holds every stage and fills the pipe with bubbles.
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      lu_cnt_q      <= 2'd0;
      timer_q       <= 8'd0;
      mdu_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      timer_q       <= timer_d;
      mdu_timeout_q <= mdu_timeout_d;
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ctrl_state  = reset ? state_q : RUN;
  assign mdu_timeout = mdu_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs1, ifid_use_rs2, idex_mem_read, idex_valid;
  logic       ex_redirect, mdu_start, mdu_done, imem_ready;

  // dut a: LU_BUBBLES=2, MDU_TIMEOUT=4, CNT_W=4
  logic       a_pc_en, a_ifid_en, a_idex_en, a_ifid_flush, a_idex_flush, a_exmem_flush;
  logic [1:0] a_state;
  logic       a_tmo;
  logic [3:0] a_stall, a_flush;
  // dut b: defaults
  logic        b_pc_en, b_ifid_en, b_idex_en, b_ifid_flush, b_idex_flush, b_exmem_flush;
  logic [1:0]  b_state;
  logic        b_tmo;
  logic [15:0] b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .MDU_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .idex_valid(idex_valid),
    .ex_redirect(ex_redirect), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .imem_ready(imem_ready),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush),
    .ctrl_state(a_state), .mdu_timeout(a_tmo),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl dut_b (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .idex_valid(idex_valid),
    .ex_redirect(ex_redirect), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .imem_ready(imem_ready),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush),
    .ctrl_state(b_state), .mdu_timeout(b_tmo),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
    idex_rd = 5'd0; idex_mem_read = 1'b0; idex_valid = 1'b0;
    ex_redirect = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic set_load_use();
    idex_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd5;
    ifid_rs1 = 5'd5; ifid_use_rs1 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    // reset with conflicting inputs
    idle();
    reset = 1'b0; ex_redirect = 1'b1; imem_ready = 1'b0; mdu_start = 1'b1;
    settle();
    chk("rst_en", {a_pc_en, a_ifid_en, a_idex_en}, 3'b000);
    chk("rst_flush", {a_ifid_flush, a_idex_flush, a_exmem_flush}, 3'b111);
    chk("rst_state", a_state, 2'd0);
    tick(); tick();
    chk("rst_cnt", {a_stall, a_flush, a_tmo}, 9'd0);
    reset = 1'b1; idle();
    settle();
    chk("normal_out", {a_pc_en, a_ifid_en, a_idex_en, a_ifid_flush, a_idex_flush, a_exmem_flush}, 6'b111000);

    // load to x0 never stalls
    idex_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1'b1;
    settle();
    chk("x0_no_stall", {a_pc_en, b_pc_en}, 2'b11);
    // matching rd but source not used: no stall
    idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_use_rs1 = 1'b0;
    settle();
    chk("unused_src", a_pc_en, 1'b1);
    tick();

    // load-use: a has two bubbles, b one
    idle(); set_load_use();
    settle();
    chk("lu0_out", {a_pc_en, a_ifid_en, a_idex_en, a_idex_flush}, 4'b0011);
    chk("lu0_state", a_state, 2'd0);
    tick();
    idle();
    settle();
    chk("lu1_a", {a_state, a_pc_en}, 3'b010);
    chk("lu1_b", {b_state, b_pc_en}, 3'b001);
    tick();
    settle();
    chk("lu2_a", {a_state, a_pc_en}, 3'b001);
    chk("lu_stall_a", a_stall, 4'd2);
    chk("lu_stall_b", b_stall, 16'd1);

    // rs2 dependency on b (one bubble, stays in RUN)
    idex_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd9;
    ifid_rs1 = 5'd3; ifid_rs2 = 5'd9; ifid_use_rs2 = 1'b1;
    settle();
    chk("rs2_b", {b_pc_en, b_ifid_en, b_idex_flush}, 3'b001);
    reset = 1'b0;
    tick();
    reset = 1'b1; idle();

    // redirect beats load-use and fetch miss
    ex_redirect = 1'b1; set_load_use(); imem_ready = 1'b0;
    settle();
    chk("redir_out", {a_pc_en, a_ifid_en, a_idex_en, a_ifid_flush, a_idex_flush, a_exmem_flush}, 6'b111110);
    tick();
    idle();
    settle();
    chk("redir_cnt_a", {a_flush, a_stall}, {4'd1, 4'd0});
    chk("redir_cnt_b", {b_flush, b_stall}, {16'd1, 16'd0});
    chk("redir_state", a_state, 2'd0);

    // MDU: b waits for done at cycle 5, a times out on its 4th busy cycle
    mdu_start = 1'b1;
    settle();
    chk("mdu0_b", {b_pc_en, b_ifid_en, b_idex_en, b_exmem_flush}, 4'b0001);
    tick();
    mdu_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("mdu_b_idex_en", b_idex_en, 1'b0);
      chk("mdu_b_state", b_state, 2'd2);
      chk("mdu_a_pc_en", a_pc_en, (c == 4) ? 1'b1 : 1'b0);
      tick();
    end
    mdu_done = 1'b1;
    settle();
    chk("mdu5_b", {b_idex_en, b_exmem_flush, b_state}, {1'b1, 1'b0, 2'd2});
    chk("wdog_a", {a_tmo, a_state}, 3'b100);
    tick();
    idle();
    settle();
    chk("mdu6_b", {b_state, b_tmo}, 3'b000);
    chk("mdu_stall_b", b_stall, 16'd5);
    chk("mdu_stall_a", a_stall, 4'd4);
    tick(); tick(); tick();
    chk("wdog_sticky", a_tmo, 1'b1);

    // reset aborts MDU_BUSY
    mdu_start = 1'b1;
    tick();
    idle();
    settle();
    chk("abort_mdu_busy", {a_state, b_state}, 4'b1010);
    reset = 1'b0;
    settle();
    chk("abort_mdu_rst", {a_state, a_pc_en, a_exmem_flush}, 4'b0001);
    tick();
    reset = 1'b1;
    settle();
    chk("abort_mdu_after", {a_state, b_state, a_pc_en, b_pc_en, a_tmo}, 7'b0000110);

    // reset aborts LU_STALL
    set_load_use();
    tick();
    idle();
    settle();
    chk("abort_lu_stall", a_state, 2'd1);
    reset = 1'b0;
    settle();
    chk("abort_lu_rst_state", a_state, 2'd0);
    tick();
    reset = 1'b1;
    settle();
    chk("abort_lu_after", {a_state, a_pc_en, a_idex_flush, a_stall}, {2'd0, 1'b1, 1'b0, 4'd0});

    // fetch miss: saturation on 4-bit counter
    imem_ready = 1'b0;
    settle();
    chk("miss_out", {a_pc_en, a_ifid_en, a_idex_en, a_ifid_flush, a_idex_flush}, 5'b01110);
    for (int i = 0; i < 20; i++) tick();
    idle();
    settle();
    chk("sat_a", a_stall, 4'd15);
    chk("sat_b", b_stall, 16'd20);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    chk("sat_rst", {a_stall, a_flush, b_stall, b_flush}, 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_BUBBLES, default 1, meaning load-use stall length in cycles (legal 1..3).
REQ-002 SHALL have parameter MDU_TIMEOUT, default 64, meaning maximum MDU_BUSY cycles before forced release (legal 2..255).
REQ-003 SHALL have parameter CNT_W, default 16, meaning performance counter width.
REQ-004 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID
- ifid_use_rs1, ifid_use_rs2  in  1 each  the ID instruction reads the corresponding source
- idex_rd  in  5  destination of the instruction in EX
- idex_mem_read  in  1  the EX instruction is a load
- idex_valid  in  1  EX holds a real instruction
- ex_redirect  in  1  branch/jump in EX redirects the PC
- mdu_start  in  1  multicycle mul/div enters EX this cycle
- mdu_done  in  1  MDU result is ready this cycle
- imem_ready  in  1  fetch data is valid this cycle
- pc_en, ifid_en, idex_en  out  1 each  stage register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble into that stage register at the next edge
- ctrl_state  out  2  RUN=0, LU_STALL=1, MDU_BUSY=2
- mdu_timeout  out  1  sticky flag; MDU watchdog fired
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

Function
REQ-005 SHALL implement an FSM {RUN, LU_STALL, MDU_BUSY}; control outputs are combinational from state and inputs, and state/counters are registered.
REQ-006 Default (normal) outputs: pc_en=ifid_en=idex_en=1 and all flush outputs 0.
REQ-007 Load-use hazard: idex_valid & idex_mem_read & idex_rd!=0 & ((idex_rd==ifid_rs1 & ifid_use_rs1) | (idex_rd==ifid_rs2 & ifid_use_rs2)).
REQ-008 RUN priority SHALL be ex_redirect > mdu_start > load-use > !imem_ready > normal.
REQ-009 RUN with ex_redirect: default enables, ifid_flush=1, idex_flush=1; flush_cnt increments; next state RUN.
REQ-010 RUN with mdu_start & !mdu_done: pc_en=ifid_en=idex_en=0, exmem_flush=1; watchdog timer cleared to 0; next state MDU_BUSY.
REQ-011 RUN with mdu_start & mdu_done in the same cycle: normal outputs; state stays RUN.
REQ-012 RUN with load-use: pc_en=ifid_en=0, idex_flush=1; if LU_BUBBLES==1, next state RUN; else next state LU_STALL with lu_cnt=LU_BUBBLES-1.
REQ-013 LU_STALL: same outputs as REQ-012; lu_cnt decrements each cycle; the transition to RUN occurs on the cycle lu_cnt==1; ex_redirect and mdu_start are ignored.
REQ-014 RUN with !imem_ready only: pc_en=0, ifid_flush=1; other outputs default.
REQ-015 MDU_BUSY: pc_en=ifid_en=idex_en=0, exmem_flush=1; the timer increments each cycle; ex_redirect and load-use are ignored.
REQ-016 MDU_BUSY with mdu_done: normal outputs that cycle; next state RUN.
REQ-017 MDU_BUSY without mdu_done and timer==MDU_TIMEOUT-1: normal outputs that cycle, mdu_timeout set to 1 (sticky), next state RUN.
REQ-018 stall_cnt SHALL increment on every non-reset cycle with pc_en==0; stall_cnt and flush_cnt saturate at all-ones and never wrap.

Reset
REQ-019 While reset==0 at a rising edge: state set to RUN, lu_cnt=0, timer=0, mdu_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-020 While reset==0: pc_en=ifid_en=idex_en=0, ifid_flush=idex_flush=exmem_flush=1, ctrl_state=0, regardless of the other inputs.
REQ-021 Reset asserted in LU_STALL or MDU_BUSY SHALL abort the operation; the first cycle after release is RUN with normal outputs (given no hazard inputs).

Verification
REQ-022 Load-use, LU_BUBBLES=2: idex_mem_read=1, idex_valid=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 -> pc_en=0 for exactly 2 cycles; ctrl_state goes 0,1,0; stall_cnt=2.
REQ-023 Load with rd=x0: idex_rd=0, ifid_rs1=0 -> no stall; pc_en stays 1.
REQ-024 MDU: mdu_start at cycle 0, mdu_done at cycle 5 -> idex_en=0 in cycles 0..4 and 1 in cycle 5; ctrl_state=0 at cycle 6; mdu_timeout=0.
REQ-025 Watchdog, MDU_TIMEOUT=4: mdu_start, no mdu_done -> release on the 4th MDU_BUSY cycle; mdu_timeout=1 and remains 1 until reset.
REQ-026 Simultaneous ex_redirect, load-use and !imem_ready in RUN -> only the redirect response (ifid_flush=idex_flush=1, pc_en=1); flush_cnt +1; stall_cnt unchanged.
REQ-027 Saturation, CNT_W=4: hold imem_ready=0 for 20 cycles -> stall_cnt=15; reset==0 for one cycle -> all counters 0.
